// File: rtl/clk_enable_gen_if.sv
// Control/status bundle for clk_enable_gen: increment loading, run enable,
// and the per-channel clock-enable outputs with busy/locked status.
interface clk_enable_gen_if #(
    parameter int CHANNELS = 2,
    parameter int ACC_W    = 32
);
    logic                enable;
    logic                load;
    logic [2:0]          ch_sel;
    logic [ACC_W-1:0]    inc_data;
    logic [CHANNELS-1:0] ce;
    logic                busy;
    logic                locked;

    modport master (
        output enable, load, ch_sel, inc_data,
        input  ce, busy, locked
    );

    modport slave (
        input  enable, load, ch_sel, inc_data,
        output ce, busy, locked
    );
endinterface

// File: rtl/clk_enable_gen.sv
// Multi-channel phase-accumulator clock-enable generator. Each channel emits a
// one-cycle ce pulse per accumulator wrap; new increments are applied glitch-free.
module clk_enable_gen_ch #(
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             load_hit,
    input  logic [ACC_W-1:0] load_data,
    output logic             ce,
    output logic             pend_v
);
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc;
    logic [ACC_W-1:0] pend;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic             apply;

    // Swap increments only on a wrap (or when stopped) so no short period escapes.
    always_comb begin
        sum   = {1'b0, acc} + {1'b0, inc};
        carry = enable & sum[ACC_W];
        apply = pend_v & (carry | (inc == '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            inc    <= '0;
            pend   <= '0;
            pend_v <= 1'b0;
            ce     <= 1'b0;
        end else begin
            if (enable)
                acc <= sum[ACC_W-1:0];
            ce <= carry;
            if (apply)
                inc <= pend;
            // A load coinciding with an apply re-arms with the new value.
            if (load_hit) begin
                pend   <= load_data;
                pend_v <= 1'b1;
            end else if (apply) begin
                pend_v <= 1'b0;
            end
        end
    end
endmodule

module clk_enable_gen #(
    parameter int CHANNELS    = 2,
    parameter int ACC_W       = 32,
    parameter int LOCK_CYCLES = 16
) (
    input logic            clk,
    input logic            rst,
    clk_enable_gen_if.slave bus
);
    localparam int LW = $clog2(LOCK_CYCLES + 1);

    logic [CHANNELS-1:0] ce_w;
    logic [CHANNELS-1:0] pend_w;
    logic [CHANNELS-1:0] hit;
    logic                accepted;
    logic                busy;
    logic [LW-1:0]       lock_cnt;

    assign accepted = bus.load && ({1'b0, bus.ch_sel} < 4'(CHANNELS));

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        assign hit[i] = bus.load && (bus.ch_sel == 3'(i));

        clk_enable_gen_ch #(.ACC_W(ACC_W)) u_ch (
            .clk       (clk),
            .rst       (rst),
            .enable    (bus.enable),
            .load_hit  (hit[i]),
            .load_data (bus.inc_data),
            .ce        (ce_w[i]),
            .pend_v    (pend_w[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            lock_cnt <= '0;
        end else begin
            busy <= |pend_w;
            if (accepted || busy)
                lock_cnt <= '0;
            else if (bus.enable && lock_cnt != LW'(LOCK_CYCLES))
                lock_cnt <= lock_cnt + 1'b1;
        end
    end

    assign bus.ce     = ce_w;
    assign bus.busy   = busy;
    assign bus.locked = (lock_cnt == LW'(LOCK_CYCLES));
endmodule

// File: tb/tb_clk_enable_gen.sv
// Directed self-checking bench for clk_enable_gen (CHANNELS=2, ACC_W=32, LOCK_CYCLES=16).
module tb_clk_enable_gen;
    localparam int CHANNELS    = 2;
    localparam int ACC_W       = 32;
    localparam int LOCK_CYCLES = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    clk_enable_gen_if #(.CHANNELS(CHANNELS), .ACC_W(ACC_W)) bus ();

    clk_enable_gen #(
        .CHANNELS(CHANNELS), .ACC_W(ACC_W), .LOCK_CYCLES(LOCK_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ld, input logic [2:0] sel, input logic [31:0] data);
        bus.load     = ld;
        bus.ch_sel   = sel;
        bus.inc_data = data;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        bus.enable = 1'b1;
        drive(1'b0, 3'd0, 32'h0);
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        rst        = 1'b1;
        bus.enable = 1'b1;
        drive(1'b1, 3'd0, 32'h8000_0000);
        step();
        checks++;
        if (bus.ce !== 2'b00 || bus.busy !== 1'b0 || bus.locked !== 1'b0) begin
            errors++;
            $display("FAIL reset_state ce=%b busy=%b locked=%b exp 00/0/0", bus.ce, bus.busy, bus.locked);
        end
        rst = 1'b0;
        drive(1'b0, 3'd0, 32'h0);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (bus.ce !== 2'b00 || bus.busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_stopped bad_cycles=%0d exp 0", bad);
        end
    endtask

    task automatic test_basic();
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            logic [1:0] exp_ce;
            logic exp_busy, exp_locked;
            drive(c == 0, 3'd0, 32'h8000_0000);
            step();
            exp_ce     = (c >= 3 && c % 2 == 1) ? 2'b01 : 2'b00;
            exp_busy   = (c == 1);
            exp_locked = (c >= 18);
            checks += 3;
            if (bus.ce !== exp_ce) begin
                errors++; $display("FAIL basic_ce c=%0d got=%b exp=%b", c, bus.ce, exp_ce);
            end
            if (bus.busy !== exp_busy) begin
                errors++; $display("FAIL basic_busy c=%0d got=%b exp=%b", c, bus.busy, exp_busy);
            end
            if (bus.locked !== exp_locked) begin
                errors++; $display("FAIL basic_locked c=%0d got=%b exp=%b", c, bus.locked, exp_locked);
            end
        end
    endtask

    task automatic test_retune();
        do_reset();
        for (int c = 0; c <= 45; c++) begin
            logic [1:0] exp_ce;
            logic exp_busy, exp_locked;
            drive(c == 0 || c == 23, 3'd0, (c == 0) ? 32'h4000_0000 : 32'h8000_0000);
            step();
            exp_ce     = ((c >= 5 && c <= 25 && (c - 5) % 4 == 0) || (c > 25 && c % 2 == 1)) ? 2'b01 : 2'b00;
            exp_busy   = (c == 1 || c == 24 || c == 25);
            exp_locked = (c >= 18 && c < 23) || (c >= 42);
            checks += 3;
            if (bus.ce !== exp_ce) begin
                errors++; $display("FAIL retune_ce c=%0d got=%b exp=%b", c, bus.ce, exp_ce);
            end
            if (bus.busy !== exp_busy) begin
                errors++; $display("FAIL retune_busy c=%0d got=%b exp=%b", c, bus.busy, exp_busy);
            end
            if (bus.locked !== exp_locked) begin
                errors++; $display("FAIL retune_locked c=%0d got=%b exp=%b", c, bus.locked, exp_locked);
            end
        end
    endtask

    task automatic test_load_on_apply();
        do_reset();
        for (int c = 0; c <= 40; c++) begin
            logic [1:0] exp_ce;
            logic exp_busy;
            logic [31:0] d;
            d = (c == 0) ? 32'h4000_0000 : (c == 11) ? 32'h8000_0000 : 32'h2000_0000;
            drive(c == 0 || c == 11 || c == 13, 3'd0, d);
            step();
            exp_ce   = (c == 5 || c == 9 || c == 13 || c == 15 || c == 23 || c == 31 || c == 39) ? 2'b01 : 2'b00;
            exp_busy = (c == 1) || (c >= 12 && c <= 15);
            checks += 2;
            if (bus.ce !== exp_ce) begin
                errors++; $display("FAIL overlap_ce c=%0d got=%b exp=%b", c, bus.ce, exp_ce);
            end
            if (bus.busy !== exp_busy) begin
                errors++; $display("FAIL overlap_busy c=%0d got=%b exp=%b", c, bus.busy, exp_busy);
            end
        end
    endtask

    task automatic test_bad_sel();
        do_reset();
        for (int c = 0; c <= 60; c++) begin
            logic [1:0] exp_ce;
            if (c == 0)       drive(1'b1, 3'd0, 32'h8000_0000);
            else if (c == 25) drive(1'b1, 3'd5, 32'h1234_5678);
            else if (c == 26) drive(1'b1, 3'd7, 32'h2000_0000);
            else              drive(1'b0, 3'd0, 32'h0);
            step();
            if (c >= 20) begin
                exp_ce = (c % 2 == 1) ? 2'b01 : 2'b00;
                checks += 3;
                if (bus.ce !== exp_ce) begin
                    errors++; $display("FAIL badsel_ce c=%0d got=%b exp=%b", c, bus.ce, exp_ce);
                end
                if (bus.busy !== 1'b0) begin
                    errors++; $display("FAIL badsel_busy c=%0d got=%b exp=0", c, bus.busy);
                end
                if (bus.locked !== 1'b1) begin
                    errors++; $display("FAIL badsel_locked c=%0d got=%b exp=1", c, bus.locked);
                end
            end
        end
    endtask

    task automatic test_mean();
        int n0, n1, first, last;
        do_reset();
        n0 = 0; n1 = 0; first = -1; last = -1;
        for (int c = 0; c <= 3001; c++) begin
            if (c == 0)      drive(1'b1, 3'd0, 32'h8000_0000);
            else if (c == 1) drive(1'b1, 3'd1, 32'h2AAA_AAAB);
            else             drive(1'b0, 3'd0, 32'h0);
            step();
            if (c >= 2) begin
                if (bus.ce[0] === 1'b1) n0++;
                if (bus.ce[1] === 1'b1) begin
                    n1++;
                    if (first < 0) first = c;
                    last = c;
                end
            end
        end
        checks++;
        if (n0 != 1500) begin
            errors++; $display("FAIL mean_ch0_count got=%0d exp=1500", n0);
        end
        checks++;
        if (n1 < 499 || n1 > 501) begin
            errors++; $display("FAIL mean_ch1_count got=%0d exp=499..501", n1);
        end
        checks++;
        if (n1 < 2 || (last - first) * 100 < (n1 - 1) * 599 || (last - first) * 100 > (n1 - 1) * 601) begin
            errors++; $display("FAIL mean_ch1_spacing span=%0d pulses=%0d exp mean 6.00", last - first, n1);
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        do_reset();
        for (int c = 0; c <= 12; c++) begin
            logic [31:0] d;
            d = (c == 0) ? 32'h4000_0000 : (c == 11) ? 32'h1000_0000 : 32'h2000_0000;
            drive(c == 0 || c == 11 || c == 12, 3'd0, d);
            step();
        end
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++; $display("FAIL b2b_busy got=%b exp=1", bus.busy);
        end
        rst = 1'b1;
        drive(1'b0, 3'd0, 32'h0);
        step();
        checks++;
        if (bus.ce !== 2'b00 || bus.busy !== 1'b0 || bus.locked !== 1'b0) begin
            errors++;
            $display("FAIL b2b_reset ce=%b busy=%b locked=%b exp 00/0/0", bus.ce, bus.busy, bus.locked);
        end
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (bus.ce !== 2'b00 || bus.busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL b2b_discard bad_cycles=%0d exp 0", bad);
        end
        for (int c = 0; c <= 3; c++) begin
            drive(c == 0, 3'd0, 32'h8000_0000);
            step();
        end
        checks++;
        if (bus.ce !== 2'b01) begin
            errors++; $display("FAIL b2b_fresh_load ce=%b exp=01", bus.ce);
        end
    endtask

    task automatic test_enable_pause();
        do_reset();
        for (int c = 0; c <= 36; c++) begin
            logic [1:0] exp_ce;
            logic exp_locked;
            bus.enable = !(c >= 15 && c <= 24);
            drive(c == 0, 3'd0, 32'h4000_0000);
            step();
            exp_ce     = (c == 5 || c == 9 || c == 13 || c == 27 || c == 31 || c == 35) ? 2'b01 : 2'b00;
            exp_locked = (c >= 28);
            checks += 2;
            if (bus.ce !== exp_ce) begin
                errors++; $display("FAIL pause_ce c=%0d got=%b exp=%b", c, bus.ce, exp_ce);
            end
            if (bus.locked !== exp_locked) begin
                errors++; $display("FAIL pause_locked c=%0d got=%b exp=%b", c, bus.locked, exp_locked);
            end
        end
        bus.enable = 1'b1;
    endtask

    initial begin
        bus.enable = 1'b0;
        drive(1'b0, 3'd0, 32'h0);
        test_reset();
        test_basic();
        test_retune();
        test_load_on_apply();
        test_bad_sel();
        test_mean();
        test_back_to_back();
        test_enable_pause();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/clk_enable_gen.md
CLK_ENABLE_GEN -- requirements
Module: clk_enable_gen

Interface
REQ-001 The block SHALL provide parameter CHANNELS, default 2, giving the number of independent clock-enable channels (1..8).
REQ-002 The block SHALL provide parameter ACC_W, default 32, giving the phase accumulator and increment width in bits.
REQ-003 The block SHALL provide parameter LOCK_CYCLES, default 16, giving the settle count after any reprogramming.
REQ-004 The block SHALL provide port clk, input, 1 bit: the single system clock, i.e. the PLL output clock.
REQ-005 The block SHALL provide port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL provide port enable, input, 1 bit: global run; low freezes all accumulators.
REQ-007 The block SHALL provide port load, input, 1 bit: single-cycle strobe requesting an increment write.
REQ-008 The block SHALL provide port ch_sel, input, 3 bits: target channel for load.
REQ-009 The block SHALL provide port inc_data, input, ACC_W bits: new increment value for load.
REQ-010 The block SHALL provide port ce, output, CHANNELS bits: per-channel one-cycle clock-enable pulses.
REQ-011 The block SHALL provide port busy, output, 1 bit: at least one increment write is pending.
REQ-012 The block SHALL provide port locked, output, 1 bit: all channels are running on stable, applied increments.

Function
REQ-013 Each channel SHALL hold acc[ACC_W-1:0], inc[ACC_W-1:0], pend[ACC_W-1:0] and a pend_v flag.
REQ-014 On every cycle with enable=1, each channel SHALL compute {carry,acc} <= acc + inc, modulo 2^ACC_W.
REQ-015 ce[i] SHALL be the registered carry: 1 cycle of latency, high for exactly one cycle per accumulator wrap.
REQ-016 The output frequency SHALL be f_clk*inc/2^ACC_W; inc=0 SHALL stop the channel with ce[i]=0.
REQ-017 With enable=0, acc SHALL hold, ce SHALL be all 0 on the next cycle, and the lock counter SHALL hold.
REQ-018 load=1 with ch_sel<CHANNELS SHALL set pend<=inc_data and pend_v<=1 for that channel on the next edge.
REQ-019 load with ch_sel>=CHANNELS SHALL be ignored entirely: no state change, locked unaffected.
REQ-020 A pending increment SHALL be applied (inc<=pend, pend_v<=0) on the cycle the channel's carry is 1, so no runt period is produced.
REQ-021 If the channel's current inc=0, the pending increment SHALL be applied on the cycle after load, without waiting for a carry.
REQ-022 A load to a channel that already has pend_v=1 SHALL overwrite pend; busy SHALL remain 1.
REQ-023 If load and an apply fall in the same cycle for the same channel, the apply SHALL use the old pend, and the new value SHALL become pending with pend_v=1.
REQ-024 The accumulator SHALL NOT be cleared by load or by apply; phase continuity SHALL be preserved.
REQ-025 busy SHALL be the registered OR of all pend_v flags.
REQ-026 A lock counter SHALL clear on any accepted load and while busy=1, and SHALL otherwise increment when enable=1, saturating at LOCK_CYCLES.
REQ-027 locked SHALL be 1 exactly when the lock counter equals LOCK_CYCLES, and SHALL drop on the cycle after an accepted load.

Reset
REQ-028 rst=1 at a clock edge SHALL set all acc, inc and pend to 0, all pend_v to 0, the lock counter to 0, ce=0, busy=0 and locked=0.
REQ-029 rst SHALL take priority over load and enable, and a reset asserted mid-operation SHALL discard any pending increments.
REQ-030 After reset, all channels SHALL remain stopped (ce=0) until they are loaded.

Verification
REQ-031 Reset, then load ch0 with 0x80000000 and enable=1 -> busy pulses; ce[0] asserts every 2nd cycle; locked=1 sixteen cycles after busy falls.
REQ-032 ch0 running at 0x40000000 (period 4), then load 0x80000000 -> the new period takes effect only at the next ce[0], with no interval shorter than 2 cycles; locked drops, then recovers.
REQ-033 Load ch1 with 0x2AAAAAAB -> the mean ce[1] spacing over 3000 cycles is 6.000±0.01 cycles; ch0 cadence is unaffected.
REQ-034 Load with ch_sel=5 and CHANNELS=2 -> no change to ce, busy or locked.
REQ-035 Back-to-back loads to ch0 while pending, then rst asserted mid-pending -> all outputs are 0 the next cycle, and no ce appears until a fresh load.
REQ-036 Toggle enable=0 for 10 cycles -> ce=0 and acc is frozen; the cadence resumes at the same phase after enable returns.
